// File: rtl/dm_uart_ctrl.sv
// MEM-stage data-memory controller: routes each load/store to the Ram1 SRAM or the
// memory-mapped UART that shares the Ram1 data bus, stalling the pipeline meanwhile.
module dm_uart_ctrl #(
  parameter logic [15:0] UART_DATA_ADDR = 16'hBF00,
  parameter logic [15:0] UART_STAT_ADDR = 16'hBF01,
  parameter int unsigned SRAM_WAIT      = 0
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [15:0] Addr,
  input  logic [15:0] DataIn,
  input  logic        MemRead,
  input  logic        MemWrite,
  output logic [15:0] DataOut,
  output logic        Stall,
  output logic        Ram1_EN,
  output logic        Ram1_OE,
  output logic        Ram1_WE,
  output logic [17:0] Ram1_address,
  inout  wire  [15:0] Ram1_data,
  output logic        rdn,
  output logic        wrn,
  input  logic        data_ready,
  input  logic        tbre,
  input  logic        tsre,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SRAM_RD  = 3'd1,
    SRAM_WR  = 3'd2,
    UART_RD1 = 3'd3,
    UART_RD2 = 3'd4,
    UART_WR1 = 3'd5,
    UART_WR2 = 3'd6,
    DONE     = 3'd7
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] dout_q, dout_d;
  logic [15:0] wdata_q, wdata_d;
  logic        wr_done_q, wr_done_d;
  logic [2:0]  sync1_q, sync2_q;

  logic        req;
  logic        drive;
  logic [15:0] status;

  // Handshake: a request (MemRead|MemWrite) is held by the pipeline while Stall is
  // high; Stall drops only in DONE, and the pipeline advances on that edge.
  assign req    = MemRead | MemWrite;
  assign status = {14'b0, sync2_q[2], sync2_q[1] & sync2_q[0]};

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q   <= IDLE;
      cnt_q     <= 3'd0;
      dout_q    <= 16'h0000;
      wdata_q   <= 16'h0000;
      wr_done_q <= 1'b0;
      sync1_q   <= 3'b000;
      sync2_q   <= 3'b000;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dout_q    <= dout_d;
      wdata_q   <= wdata_d;
      wr_done_q <= wr_done_d;
      sync1_q   <= {data_ready, tbre, tsre};
      sync2_q   <= sync1_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dout_d    = dout_q;
    wdata_d   = wdata_q;
    wr_done_d = wr_done_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          wr_done_d = 1'b0;
          if (Addr == UART_STAT_ADDR) begin
            // A status write has nothing to update; it just completes.
            if (!MemWrite) dout_d = status;
            state_d = DONE;
          end else if (Addr == UART_DATA_ADDR) begin
            if (MemWrite) begin
              wdata_d   = {8'h00, DataIn[7:0]};
              wr_done_d = 1'b1;
              state_d   = UART_WR1;
            end else begin
              state_d = UART_RD1;
            end
          end else begin
            cnt_d = 3'(SRAM_WAIT);
            if (MemWrite) begin
              wdata_d   = DataIn;
              wr_done_d = 1'b1;
              state_d   = SRAM_WR;
            end else begin
              state_d = SRAM_RD;
            end
          end
        end
      end
      SRAM_RD: begin
        if (cnt_q != 3'd0) begin
          cnt_d = cnt_q - 3'd1;
        end else begin
          dout_d  = Ram1_data;
          state_d = DONE;
        end
      end
      SRAM_WR: begin
        if (cnt_q != 3'd0) cnt_d = cnt_q - 3'd1;
        else               state_d = DONE;
      end
      UART_RD1: state_d = UART_RD2;
      UART_RD2: begin
        dout_d  = {8'h00, Ram1_data[7:0]};
        state_d = DONE;
      end
      UART_WR1: state_d = UART_WR2;
      UART_WR2: state_d = DONE;
      DONE: begin
        wr_done_d = 1'b0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Strobes decode from the state register alone, so an async reset clears them at once.
  always_comb begin
    Ram1_EN = 1'b1;
    Ram1_OE = 1'b1;
    Ram1_WE = 1'b1;
    rdn     = 1'b1;
    wrn     = 1'b1;
    drive   = 1'b0;
    case (state_q)
      SRAM_RD: begin
        Ram1_EN = 1'b0;
        Ram1_OE = 1'b0;
      end
      SRAM_WR: begin
        Ram1_EN = 1'b0;
        Ram1_WE = 1'b0;
        drive   = 1'b1;
      end
      UART_RD1, UART_RD2: rdn = 1'b0;
      UART_WR1: begin
        wrn   = 1'b0;
        drive = 1'b1;
      end
      UART_WR2: drive = 1'b1;
      DONE:     drive = wr_done_q;
      default: ;
    endcase
  end

  assign Stall        = Rst & (((state_q == IDLE) & req) |
                               ((state_q != IDLE) & (state_q != DONE)));
  assign DataOut      = dout_q;
  assign Ram1_address = {2'b00, Addr};
  assign Ram1_data    = drive ? wdata_q : 16'hzzzz;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_dm_uart_ctrl.sv
// Directed bench for dm_uart_ctrl: one instance with SRAM_WAIT=0, one with SRAM_WAIT=2,
// expected load data queued at issue and compared by a monitor whenever DONE is seen.
module tb_dm_uart_ctrl;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_URD1 = 3'd3;
  localparam logic [2:0] S_DONE = 3'd7;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // ---------------- shared stimulus ----------------
  logic [15:0] addr, din;
  logic        mem_rd, mem_wr, mem_rd2, mem_wr2;
  logic        data_ready, tbre, tsre;

  // ---------------- DUT 0 (SRAM_WAIT=0) ----------------
  logic [15:0] dout0;
  logic        stall0, en0, oe0, we0, rdn0, wrn0;
  logic [17:0] ra0;
  logic [2:0]  st0;
  logic [15:0] ext0;
  wire  [15:0] bus0;
  assign bus0 = (!oe0 || !rdn0) ? ext0 : 16'hzzzz;

  dm_uart_ctrl #(.SRAM_WAIT(0)) u_dut0 (
    .Clk(clk), .Rst(rst_n), .Addr(addr), .DataIn(din), .MemRead(mem_rd), .MemWrite(mem_wr),
    .DataOut(dout0), .Stall(stall0), .Ram1_EN(en0), .Ram1_OE(oe0), .Ram1_WE(we0),
    .Ram1_address(ra0), .Ram1_data(bus0), .rdn(rdn0), .wrn(wrn0),
    .data_ready(data_ready), .tbre(tbre), .tsre(tsre), .dbg_state(st0)
  );

  // ---------------- DUT 2 (SRAM_WAIT=2) ----------------
  logic [15:0] dout2;
  logic        stall2, en2, oe2, we2, rdn2, wrn2;
  logic [17:0] ra2;
  logic [2:0]  st2;
  logic [15:0] ext2;
  wire  [15:0] bus2;
  assign bus2 = (!oe2 || !rdn2) ? ext2 : 16'hzzzz;

  dm_uart_ctrl #(.SRAM_WAIT(2)) u_dut2 (
    .Clk(clk), .Rst(rst_n), .Addr(addr), .DataIn(din), .MemRead(mem_rd2), .MemWrite(mem_wr2),
    .DataOut(dout2), .Stall(stall2), .Ram1_EN(en2), .Ram1_OE(oe2), .Ram1_WE(we2),
    .Ram1_address(ra2), .Ram1_data(bus2), .rdn(rdn2), .wrn(wrn2),
    .data_ready(data_ready), .tbre(tbre), .tsre(tsre), .dbg_state(st2)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] exp0_q[$];
  logic [15:0] exp2_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && st0 == S_DONE) begin
      if (exp0_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL dout0_unexpected: got %0h expected none", dout0);
      end else begin
        chk("dout0", dout0, exp0_q.pop_front());
      end
      chk("stall0_in_done", stall0, 0);
    end
  end

  always @(negedge clk) begin
    if (rst_n && st2 == S_DONE) begin
      if (exp2_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL dout2_unexpected: got %0h expected none", dout2);
      end else begin
        chk("dout2", dout2, exp2_q.pop_front());
      end
      chk("stall2_in_done", stall2, 0);
    end
  end

  // ---------------- driver ----------------
  int          c_stall, c_we, c_oe, c_rdn, c_wrn, c_en_lo;
  logic [15:0] wbus;
  logic [17:0] waddr;

  task automatic access0(input logic rd, input logic wr, input logic [15:0] a,
                         input logic [15:0] d, input logic [15:0] ext);
    bit done;
    c_stall = 0; c_we = 0; c_oe = 0; c_rdn = 0; c_wrn = 0; c_en_lo = 0;
    wbus = 16'h0000; waddr = 18'h0;
    done = 1'b0;
    @(posedge clk); #1;
    addr = a; din = d; mem_rd = rd; mem_wr = wr; ext0 = ext;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!we0)  begin c_we++;  wbus = bus0; waddr = ra0; end
      if (!wrn0) begin c_wrn++; wbus = bus0; waddr = ra0; end
      if (!oe0)  c_oe++;
      if (!rdn0) c_rdn++;
      if (!en0)  c_en_lo++;
      if (!stall0) begin
        done = 1'b1;
        break;
      end
      c_stall++;
    end
    if (!done) chk("access0_timeout", 1, 0);
    @(posedge clk); #1;
    mem_rd = 1'b0; mem_wr = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst_n = 1'b0;
    addr = 16'h0; din = 16'h0; mem_rd = 1'b0; mem_wr = 1'b0; mem_rd2 = 1'b0; mem_wr2 = 1'b0;
    data_ready = 1'b0; tbre = 1'b0; tsre = 1'b0; ext0 = 16'h0; ext2 = 16'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_dout",  dout0, 16'h0000);
    chk("rst_stall", stall0, 0);
    chk("rst_strobes", {en0, oe0, we0, rdn0, wrn0}, 5'b11111);
    chk("rst_state", st0, S_IDLE);
    rst_n = 1'b1;

    // SRAM store then load, no wait states
    exp0_q.push_back(16'h0000);
    access0(1'b0, 1'b1, 16'h4000, 16'h1234, 16'h0000);
    chk("st_stall", c_stall, 2);
    chk("st_we_cycles", c_we, 1);
    chk("st_oe_cycles", c_oe, 0);
    chk("st_addr", waddr, 18'h04000);
    chk("st_bus", wbus, 16'h1234);

    exp0_q.push_back(16'h1234);
    access0(1'b1, 1'b0, 16'h4000, 16'h0000, 16'h1234);
    chk("ld_stall", c_stall, 2);
    chk("ld_oe_cycles", c_oe, 1);
    chk("ld_we_cycles", c_we, 0);

    // SRAM load with two wait states
    exp2_q.push_back(16'h5678);
    c_stall = 0; c_oe = 0;
    @(posedge clk); #1;
    addr = 16'h4000; mem_rd2 = 1'b1; ext2 = 16'h5678;
    begin
      bit done2 = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (!oe2) c_oe++;
        if (!stall2) begin done2 = 1'b1; break; end
        c_stall++;
      end
      if (!done2) chk("wait2_timeout", 1, 0);
    end
    @(posedge clk); #1;
    mem_rd2 = 1'b0;
    chk("w2_oe_cycles", c_oe, 3);
    chk("w2_stall", c_stall, 4);

    // UART status word
    tbre = 1'b1; tsre = 1'b1; data_ready = 1'b0;
    repeat (3) @(posedge clk);
    exp0_q.push_back(16'h0001);
    access0(1'b1, 1'b0, 16'hBF01, 16'h0000, 16'h0000);
    chk("stat_stall", c_stall, 1);
    chk("stat_en_lo", c_en_lo, 0);
    data_ready = 1'b1;
    repeat (3) @(posedge clk);
    exp0_q.push_back(16'h0003);
    access0(1'b1, 1'b0, 16'hBF01, 16'h0000, 16'h0000);
    chk("stat2_stall", c_stall, 1);

    // status write is ignored
    exp0_q.push_back(16'h0003);
    access0(1'b0, 1'b1, 16'hBF01, 16'hFFFF, 16'h0000);
    chk("statwr_strobes", c_we + c_wrn, 0);

    // UART data write
    exp0_q.push_back(16'h0003);
    access0(1'b0, 1'b1, 16'hBF00, 16'hAB5A, 16'h0000);
    chk("uwr_wrn_cycles", c_wrn, 1);
    chk("uwr_bus", wbus, 16'h005A);
    chk("uwr_en_lo", c_en_lo, 0);
    chk("uwr_stall", c_stall, 3);
    chk("uwr_we_cycles", c_we, 0);

    // UART data read; upper byte on the bus must be dropped
    exp0_q.push_back(16'h00C3);
    access0(1'b1, 1'b0, 16'hBF00, 16'h0000, 16'hFFC3);
    chk("urd_rdn_cycles", c_rdn, 2);
    chk("urd_en_lo", c_en_lo, 0);
    chk("urd_stall", c_stall, 3);

    // read and write together is a write
    exp0_q.push_back(16'h00C3);
    access0(1'b1, 1'b1, 16'h4004, 16'hBEEF, 16'h1111);
    chk("both_we_cycles", c_we, 1);
    chk("both_oe_cycles", c_oe, 0);
    chk("both_bus", wbus, 16'hBEEF);

    // reset in the middle of a UART read
    @(posedge clk); #1;
    addr = 16'hBF00; mem_rd = 1'b1; ext0 = 16'hFFC3;
    @(posedge clk); #1;
    chk("abort_state", st0, S_URD1);
    chk("abort_rdn_before", rdn0, 0);
    rst_n = 1'b0;
    #1;
    chk("abort_rdn", rdn0, 1);
    chk("abort_stall", stall0, 0);
    chk("abort_en", en0, 1);
    @(posedge clk); #1;
    mem_rd = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_state", st0, S_IDLE);
    chk("post_dout", dout0, 16'h0000);
    chk("post_stall", stall0, 0);

    repeat (2) @(posedge clk);
    chk("exp0_empty", exp0_q.size(), 0);
    chk("exp2_empty", exp2_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
